stopwatch_display: RTL

Display back-end for the stopwatch: samples the hours/minutes/seconds/centiseconds count once per refresh frame and converts each field to two BCD digits with a sequential double-dabble engine. It then time-multiplexes the eight digits onto a common-anode 7-segment display as HH.MM.SS.cc. It sits directly downstream of the stopwatch counter and drives the board's anode, segment and decimal-point pins.

---
 rtl/stopwatch_display.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_display.sv
// Stopwatch display back-end: snapshots HH:MM:SS.cc each frame, converts each field to BCD with a
// sequential double-dabble engine, and scans eight common-anode 7-segment digits.
module stopwatch_display #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [6:0] centis,
    input  logic       blank,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
    localparam logic [3:0] DigDash = 4'hA;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic          pending_q;
    logic          tick, frame_start;

    logic [5:0] snap_h_q, snap_m_q, snap_s_q;
    logic [6:0] snap_c_q;
    logic       snap_load;

    state_e     state_q, state_d;
    logic [1:0] field_q, field_d;
    logic [2:0] shcnt_q, shcnt_d;
    logic [6:0] bin_q, bin_d;
    logic [7:0] bcd_q, bcd_d;
    logic [3:0] stage_q [8];
    logic [3:0] stage_d [8];
    logic [3:0] digit_q [8];
    logic [3:0] digit_d [8];

    logic [6:0] fld;
    logic [7:0] adj;
    logic [7:0] bcd_sh;
    logic [6:0] bin_sh;

    logic [7:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic [3:0] cur;

    assign tick        = (cnt_q == CntMax);
    assign frame_start = pending_q | (tick & (idx_q == 3'd7));

    always_comb begin
        unique case (field_q)
            2'd0:    fld = snap_c_q;
            2'd1:    fld = {1'b0, snap_s_q};
            2'd2:    fld = {1'b0, snap_m_q};
            default: fld = {1'b0, snap_h_q};
        endcase
    end

    // Add-3 correction on each BCD nibble, then shift {bcd, bin} left by one.
    always_comb begin
        adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        bcd_sh   = {adj[6:0], bin_q[6]};
        bin_sh   = {bin_q[5:0], 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        shcnt_d   = shcnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        stage_d   = stage_q;
        digit_d   = digit_q;
        snap_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    snap_load = 1'b1;
                    field_d   = 2'd0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                bin_d   = fld;
                bcd_d   = 8'd0;
                shcnt_d = 3'd0;
                state_d = StShift;
            end
            StShift: begin
                bin_d   = bin_sh;
                bcd_d   = bcd_sh;
                shcnt_d = shcnt_q + 3'd1;
                if (shcnt_q == 3'd6) begin
                    if (fld > 7'd99) begin
                        stage_d[{field_q, 1'b0}] = DigDash;
                        stage_d[{field_q, 1'b1}] = DigDash;
                    end else begin
                        stage_d[{field_q, 1'b0}] = bcd_sh[3:0];
                        stage_d[{field_q, 1'b1}] = bcd_sh[7:4];
                    end
                    if (field_q == 2'd3) begin
                        state_d = StDone;
                    end else begin
                        field_d = field_q + 2'd1;
                        state_d = StLoad;
                    end
                end
            end
            default: begin
                digit_d = stage_q;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cur = digit_q[idx_q];
        unique case (cur)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            DigDash: seg_d = 7'h3F;
            default: seg_d = 7'h7F;
        endcase
        // Hours tens is the only leading zero suppressed.
        if ((idx_q == 3'd7) && (cur == 4'd0)) begin
            seg_d = 7'h7F;
        end
        an_d = blank ? 8'hFF : ~(8'h01 << idx_q);
        dp_d = blank ? 1'b1 : ~((idx_q == 3'd2) | (idx_q == 3'd4) | (idx_q == 3'd6));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            pending_q <= 1'b1;
            snap_h_q  <= 6'd0;
            snap_m_q  <= 6'd0;
            snap_s_q  <= 6'd0;
            snap_c_q  <= 7'd0;
            state_q   <= StIdle;
            field_q   <= 2'd0;
            shcnt_q   <= 3'd0;
            bin_q     <= 7'd0;
            bcd_q     <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                stage_q[i] <= 4'd0;
                digit_q[i] <= 4'd0;
            end
            an        <= 8'hFF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            cnt_q     <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                idx_q <= idx_q + 3'd1;
            end
            pending_q <= 1'b0;
            if (snap_load) begin
                snap_h_q <= hours;
                snap_m_q <= minutes;
                snap_s_q <= seconds;
                snap_c_q <= centis;
            end
            state_q   <= state_d;
            field_q   <= field_d;
            shcnt_q   <= shcnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            stage_q   <= stage_d;
            digit_q   <= digit_d;
            an        <= an_d;
            seg       <= seg_d;
            dp        <= dp_d;
        end
    end

endmodule
